// File: rtl/gnw_asset_loader_pkg.sv
// Shared types and default geometry for the Game & Watch asset loader.
package gnw_pkg;

   localparam int unsigned ROM_SIZE_DEF   = 4096;
   localparam int unsigned PAL_SIZE_DEF   = 768;
   localparam int unsigned SCR_W_DEF      = 800;
   localparam int unsigned SCR_H_DEF      = 600;
   localparam int unsigned SDRAM_BASE_DEF = 0;

   localparam int unsigned OFFS_W = 25;

   // Default region bases in file-offset space
   localparam int unsigned PAL_BASE_DEF = ROM_SIZE_DEF;
   localparam int unsigned SCR_BASE_DEF = ROM_SIZE_DEF + PAL_SIZE_DEF;
   localparam int unsigned SCR_END_DEF  = SCR_BASE_DEF + SCR_W_DEF * SCR_H_DEF * 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      FLUSH,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      RGN_ROM,
      RGN_PAL,
      RGN_SCR,
      RGN_NONE
   } region_t;

   // Classify a file offset against the three region end points
   function automatic region_t decode_region(input logic [OFFS_W-1:0] offs,
                                             input logic [OFFS_W-1:0] pal_base,
                                             input logic [OFFS_W-1:0] scr_base,
                                             input logic [OFFS_W-1:0] scr_end);
      region_t r;
      if (offs < pal_base)      r = RGN_ROM;
      else if (offs < scr_base) r = RGN_PAL;
      else if (offs < scr_end)  r = RGN_SCR;
      else                      r = RGN_NONE;
      return r;
   endfunction

endpackage

// File: rtl/gnw_asset_loader_if.sv
// SDRAM write bus between the asset loader and the memory controller.
interface gnw_asset_loader_if;

   logic [24:0] sdram_addr;
   logic [15:0] sdram_din;
   logic        sdram_we;
   logic        sdram_ack;

   modport master (
      output sdram_addr,
      output sdram_din,
      output sdram_we,
      input  sdram_ack
   );

   modport slave (
      input  sdram_addr,
      input  sdram_din,
      input  sdram_we,
      output sdram_ack
   );

endinterface

// File: rtl/gnw_asset_loader_word_packer.sv
// Pairs image bytes into 16-bit {cid,mask} words and holds the SDRAM
// request (and the HPS stall) until the controller acknowledges it.
module gnw_word_packer
   import gnw_pkg::*;
#(
   parameter int unsigned SDRAM_BASE = SDRAM_BASE_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_pend,
   input  logic               latch_en,
   input  logic               issue_en,
   input  logic               flush_en,
   input  logic [7:0]         byte_in,
   input  logic [OFFS_W-1:0]  rel_in,
   output logic               pending,
   output logic               ack_seen,
   output logic               wait_o,
   gnw_asset_loader_if.master sdram
);

   localparam logic [OFFS_W-1:0] BASE = OFFS_W'(SDRAM_BASE);
   localparam logic [OFFS_W-1:0] EVEN_MASK = ~OFFS_W'(1);

   logic [7:0]        hi_q, hi_d;
   logic              pend_q, pend_d;
   logic [OFFS_W-1:0] pend_addr_q, pend_addr_d;
   logic              we_q, we_d;
   logic              wait_q, wait_d;
   logic [OFFS_W-1:0] addr_q, addr_d;
   logic [15:0]       din_q, din_d;

   // Next-state for the byte latch and the outstanding-write holder
   always_comb begin
      hi_d        = hi_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      we_d        = we_q;
      wait_d      = wait_q;
      addr_d      = addr_q;
      din_d       = din_q;
      ack_seen    = we_q & sdram.sdram_ack;

      if (clear_pend) pend_d = 1'b0;

      if (ack_seen) begin
         we_d   = 1'b0;
         wait_d = 1'b0;
      end

      if (latch_en) begin
         hi_d        = byte_in;
         pend_d      = 1'b1;
         pend_addr_d = rel_in & EVEN_MASK;
      end

      // Odd byte pairs with whatever is in the latch, even if stale
      if (issue_en) begin
         we_d   = 1'b1;
         wait_d = 1'b1;
         addr_d = (BASE + (rel_in & EVEN_MASK)) & EVEN_MASK;
         din_d  = {hi_q, byte_in};
         pend_d = 1'b0;
      end

      // Flush may coincide with the final even byte, so use the _d view
      if (flush_en) begin
         we_d   = 1'b1;
         wait_d = 1'b1;
         addr_d = (BASE + pend_addr_d) & EVEN_MASK;
         din_d  = {hi_d, 8'h00};
         pend_d = 1'b0;
      end
   end

   // Register the latch and request state
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q        <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         we_q        <= 1'b0;
         wait_q      <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
      end else begin
         hi_q        <= hi_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         we_q        <= we_d;
         wait_q      <= wait_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
      end
   end

   assign pending          = pend_q;
   assign wait_o           = wait_q;
   assign sdram.sdram_we   = we_q;
   assign sdram.sdram_addr = addr_q;
   assign sdram.sdram_din  = din_q;

endmodule

// File: rtl/gnw_asset_loader.sv
// Routes the HPS asset download to MCU ROM, palette RAM and SDRAM image.
module gnw_asset_loader
   import gnw_pkg::*;
#(
   parameter int unsigned ROM_SIZE   = ROM_SIZE_DEF,
   parameter int unsigned PAL_SIZE   = PAL_SIZE_DEF,
   parameter int unsigned SCR_W      = SCR_W_DEF,
   parameter int unsigned SCR_H      = SCR_H_DEF,
   parameter int unsigned SDRAM_BASE = SDRAM_BASE_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ioctl_download,
   input  logic               ioctl_wr,
   input  logic [24:0]        ioctl_addr,
   input  logic [7:0]         ioctl_dout,
   output logic               ioctl_wait,
   output logic               rom_we,
   output logic [11:0]        rom_addr,
   output logic [7:0]         rom_dout,
   output logic               pal_load,
   output logic [9:0]         pal_addr,
   output logic [7:0]         pal_din,
   gnw_asset_loader_if.master sdram,
   output logic               done
);

   localparam logic [OFFS_W-1:0] PAL_BASE = OFFS_W'(ROM_SIZE);
   localparam logic [OFFS_W-1:0] SCR_BASE = OFFS_W'(ROM_SIZE + PAL_SIZE);
   localparam logic [OFFS_W-1:0] SCR_END  = OFFS_W'(ROM_SIZE + PAL_SIZE + SCR_W * SCR_H * 2);

   state_t            state_q, state_d;
   logic              dl_q;
   logic              done_q, done_d;
   logic              rom_we_q, rom_we_d;
   logic [11:0]       rom_addr_q, rom_addr_d;
   logic [7:0]        rom_dout_q, rom_dout_d;
   logic              pal_load_q, pal_load_d;
   logic [9:0]        pal_addr_q, pal_addr_d;
   logic [7:0]        pal_din_q, pal_din_d;

   region_t           region;
   logic [OFFS_W-1:0] rel_scr;
   logic              accept;
   logic              dl_rise;
   logic              clear_pend, latch_en, issue_en, flush_en;
   logic              pending, ack_seen;

   assign region  = decode_region(ioctl_addr, PAL_BASE, SCR_BASE, SCR_END);
   assign rel_scr = ioctl_addr - SCR_BASE;
   assign accept  = ioctl_wr & ~ioctl_wait;
   assign dl_rise = ioctl_download & ~dl_q;

   // Sequencing FSM plus ROM/palette strobe generation
   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      rom_we_d   = 1'b0;
      rom_addr_d = rom_addr_q;
      rom_dout_d = rom_dout_q;
      pal_load_d = 1'b0;
      pal_addr_d = pal_addr_q;
      pal_din_d  = pal_din_q;
      clear_pend = 1'b0;
      latch_en   = 1'b0;
      issue_en   = 1'b0;
      flush_en   = 1'b0;

      case (state_q)
         IDLE: begin
            if (dl_rise) begin
               state_d    = LOAD;
               done_d     = 1'b0;
               clear_pend = 1'b1;
            end
         end
         LOAD: begin
            if (accept) begin
               case (region)
                  RGN_ROM: begin
                     rom_we_d   = 1'b1;
                     rom_addr_d = ioctl_addr[11:0];
                     rom_dout_d = ioctl_dout;
                  end
                  RGN_PAL: begin
                     pal_load_d = 1'b1;
                     pal_addr_d = 10'(ioctl_addr - PAL_BASE);
                     pal_din_d  = ioctl_dout;
                  end
                  RGN_SCR: begin
                     if (rel_scr[0]) issue_en = 1'b1;
                     else            latch_en = 1'b1;
                  end
                  default: ;
               endcase
            end
            if (issue_en) begin
               state_d = WRITE;
            end else if (!ioctl_download) begin
               if (pending || latch_en) begin
                  state_d  = FLUSH;
                  flush_en = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         WRITE: begin
            if (ack_seen) begin
               if (ioctl_download) begin
                  state_d = LOAD;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         FLUSH: begin
            if (ack_seen) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered sink-port outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dl_q       <= 1'b0;
         done_q     <= 1'b0;
         rom_we_q   <= 1'b0;
         rom_addr_q <= '0;
         rom_dout_q <= '0;
         pal_load_q <= 1'b0;
         pal_addr_q <= '0;
         pal_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         dl_q       <= ioctl_download;
         done_q     <= done_d;
         rom_we_q   <= rom_we_d;
         rom_addr_q <= rom_addr_d;
         rom_dout_q <= rom_dout_d;
         pal_load_q <= pal_load_d;
         pal_addr_q <= pal_addr_d;
         pal_din_q  <= pal_din_d;
      end
   end

   gnw_word_packer #(
      .SDRAM_BASE(SDRAM_BASE)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear_pend (clear_pend),
      .latch_en   (latch_en),
      .issue_en   (issue_en),
      .flush_en   (flush_en),
      .byte_in    (ioctl_dout),
      .rel_in     (rel_scr),
      .pending    (pending),
      .ack_seen   (ack_seen),
      .wait_o     (ioctl_wait),
      .sdram      (sdram)
   );

   assign rom_we   = rom_we_q;
   assign rom_addr = rom_addr_q;
   assign rom_dout = rom_dout_q;
   assign pal_load = pal_load_q;
   assign pal_addr = pal_addr_q;
   assign pal_din  = pal_din_q;
   assign done     = done_q;

endmodule

// File: tb/tb_gnw_asset_loader.sv
// Directed bench for gnw_asset_loader.
module tb_gnw_asset_loader;
   import gnw_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        rom_we;
   logic [11:0] rom_addr;
   logic [7:0]  rom_dout;
   logic        pal_load;
   logic [9:0]  pal_addr;
   logic [7:0]  pal_din;
   logic        done;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   always #5 clk = ~clk;

   gnw_asset_loader_if bus ();

   gnw_asset_loader #(
      .ROM_SIZE   (4096),
      .PAL_SIZE   (768),
      .SCR_W      (800),
      .SCR_H      (600),
      .SDRAM_BASE (0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .rom_we         (rom_we),
      .rom_addr       (rom_addr),
      .rom_dout       (rom_dout),
      .pal_load       (pal_load),
      .pal_addr       (pal_addr),
      .pal_din        (pal_din),
      .sdram          (bus.master),
      .done           (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   initial begin
      int unsigned hi_cnt;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      bus.sdram_ack  = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      check_eq("rst_rom_we",   32'(rom_we), 0);
      check_eq("rst_pal_load", 32'(pal_load), 0);
      check_eq("rst_sdram_we", 32'(bus.sdram_we), 0);
      check_eq("rst_wait",     32'(ioctl_wait), 0);
      check_eq("rst_done",     32'(done), 0);
      check_eq("rst_addr",     32'(bus.sdram_addr), 0);
      check_eq("rst_din",      32'(bus.sdram_din), 0);
      check_eq("rst_state",    32'(dut.state_q), 32'(IDLE));

      // First download: ROM, palette, image word, flush
      ioctl_download = 1'b1;
      tick();
      check_eq("dl_state_load", 32'(dut.state_q), 32'(LOAD));

      send(25'h010, 8'hA5);
      check_eq("rom_we",      32'(rom_we), 1);
      check_eq("rom_addr",    32'(rom_addr), 32'h010);
      check_eq("rom_dout",    32'(rom_dout), 32'hA5);
      check_eq("rom_no_pal",  32'(pal_load), 0);
      check_eq("rom_no_sdr",  32'(bus.sdram_we), 0);
      tick();
      check_eq("rom_we_drop", 32'(rom_we), 0);

      send(25'd4095, 8'h5A);
      check_eq("rom_last_we",   32'(rom_we), 1);
      check_eq("rom_last_addr", 32'(rom_addr), 32'hFFF);

      send(25'd4096, 8'h12);
      check_eq("pal0_load", 32'(pal_load), 1);
      check_eq("pal0_addr", 32'(pal_addr), 0);
      check_eq("pal0_din",  32'(pal_din), 32'h12);
      check_eq("pal0_norom", 32'(rom_we), 0);
      send(25'd4097, 8'h34);
      check_eq("pal1_load", 32'(pal_load), 1);
      check_eq("pal1_addr", 32'(pal_addr), 1);
      check_eq("pal1_din",  32'(pal_din), 32'h34);

      send(25'd4864, 8'h07);
      check_eq("scr_even_no_we", 32'(bus.sdram_we), 0);
      check_eq("scr_even_no_wait", 32'(ioctl_wait), 0);
      send(25'd4865, 8'h9D);
      check_eq("scr_we",   32'(bus.sdram_we), 1);
      check_eq("scr_wait", 32'(ioctl_wait), 1);
      check_eq("scr_addr", 32'(bus.sdram_addr), 0);
      check_eq("scr_din",  32'(bus.sdram_din), 32'h079D);
      hi_cnt = 1;
      // Byte sent while stalled must be dropped
      send(25'd4867, 8'hFF);
      if (ioctl_wait) hi_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ioctl_wait) hi_cnt++;
      end
      check_eq("viol_din",  32'(bus.sdram_din), 32'h079D);
      check_eq("viol_addr", 32'(bus.sdram_addr), 0);
      check_eq("hold_we",   32'(bus.sdram_we), 1);
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      check_eq("ack_wait_drop", 32'(ioctl_wait), 0);
      check_eq("ack_we_drop",   32'(bus.sdram_we), 0);
      check_eq("wait_cycles",   hi_cnt, 6);
      check_eq("ack_to_load",   32'(dut.state_q), 32'(LOAD));

      send(25'd4866, 8'h3C);
      check_eq("flush_pre_we", 32'(bus.sdram_we), 0);
      ioctl_download = 1'b0;
      tick();
      check_eq("flush_we",   32'(bus.sdram_we), 1);
      check_eq("flush_addr", 32'(bus.sdram_addr), 2);
      check_eq("flush_din",  32'(bus.sdram_din), 32'h3C00);
      check_eq("flush_wait", 32'(ioctl_wait), 1);
      check_eq("flush_done0", 32'(done), 0);
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      check_eq("flush_ack_we", 32'(bus.sdram_we), 0);
      check_eq("flush_done",   32'(done), 1);
      tick();
      check_eq("idle_state", 32'(dut.state_q), 32'(IDLE));
      check_eq("idle_done",  32'(done), 1);

      // Second download: last image word, then a byte past the end
      ioctl_download = 1'b1;
      tick();
      check_eq("dl2_done_clr", 32'(done), 0);
      send(25'd964862, 8'hAB);
      send(25'd964863, 8'hCD);
      check_eq("last_we",   32'(bus.sdram_we), 1);
      check_eq("last_addr", 32'(bus.sdram_addr), 32'd959998);
      check_eq("last_din",  32'(bus.sdram_din), 32'hABCD);
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      send(25'd964864, 8'h55);
      check_eq("beyond_rom", 32'(rom_we), 0);
      check_eq("beyond_pal", 32'(pal_load), 0);
      check_eq("beyond_sdr", 32'(bus.sdram_we), 0);
      ioctl_download = 1'b0;
      tick();
      check_eq("beyond_done",  32'(done), 1);
      check_eq("beyond_state", 32'(dut.state_q), 32'(DONE));
      tick();

      // Third download: reset while a write is outstanding
      ioctl_download = 1'b1;
      tick();
      send(25'd4868, 8'h11);
      send(25'd4869, 8'h22);
      check_eq("pre_rst_we", 32'(bus.sdram_we), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mid_rst_we",    32'(bus.sdram_we), 0);
      check_eq("mid_rst_wait",  32'(ioctl_wait), 0);
      check_eq("mid_rst_done",  32'(done), 0);
      check_eq("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      tick();
      check_eq("reload_state", 32'(dut.state_q), 32'(LOAD));
      send(25'h020, 8'h77);
      check_eq("reload_rom_we",   32'(rom_we), 1);
      check_eq("reload_rom_addr", 32'(rom_addr), 32'h020);
      check_eq("reload_rom_dout", 32'(rom_dout), 32'h77);
      ioctl_download = 1'b0;
      tick();
      check_eq("reload_done", 32'(done), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/gnw_asset_loader.md
Name: gnw_asset_loader

Overview:
- Upstream of the LCD renderer.
- Consumes the HPS ioctl byte stream for a Game & Watch asset file and routes each region to its sink:
  - MCU program ROM bytes go to the CPU ROM write port.
  - Palette bytes go to the renderer's palette load port.
  - Screen/mask image bytes are paired into 16-bit words and written to SDRAM, where the renderer fetches them at pxaddr = (vpos*800+hpos)*2.
- Back-pressures the HPS via ioctl_wait while an SDRAM write is outstanding.

Parameters:
- ROM_SIZE, 4096, MCU ROM bytes at file offset 0.
- PAL_SIZE, 768, palette bytes (256 entries x RGB) following the ROM.
- SCR_W, 800, screen width in pixels.
- SCR_H, 600, screen height in pixels; image is SCR_W*SCR_H*2 bytes following the palette.
- SDRAM_BASE, 0, SDRAM byte address of image pixel 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  file byte offset
- ioctl_dout  in  8  file byte
- ioctl_wait  out  1  stall HPS stream
- rom_we  out  1  ROM write strobe
- rom_addr  out  12  ROM byte address
- rom_dout  out  8  ROM byte
- pal_load  out  1  palette write strobe
- pal_addr  out  10  palette byte index 0..767
- pal_din  out  8  palette byte
- sdram_addr  out  25  SDRAM byte address, even
- sdram_din  out  16  {cid,mask} word
- sdram_we  out  1  write request, held until ack
- sdram_ack  in  1  write accepted, one cycle
- done  out  1  image fully loaded; renderer enables fetch

Behaviour:
- Reset values: all outputs 0; state IDLE; hi-byte latch 0; pending flag 0.
- Region decode (combinational on ioctl_addr):
  - ROM: offset < ROM_SIZE.
  - PAL: offset < ROM_SIZE+PAL_SIZE.
  - SCR: offset < ROM_SIZE+PAL_SIZE+SCR_W*SCR_H*2.
  - Beyond that: ignored.
- ROM/PAL writes: registered, 1-cycle latency after ioctl_wr. The strobe is 1 cycle; address = offset minus region base.
- SCR bytes:
  - Even relative offset: latch into hi[7:0] (cid). No write issued.
  - Odd relative offset: sdram_din={hi,byte} and sdram_addr=SDRAM_BASE+(rel&~1) are issued on the next cycle. sdram_we=1 and ioctl_wait=1 from the same cycle.
- States:
  - IDLE: done held. Rising ioctl_download goes to LOAD, clears done and the pending flag.
  - LOAD: accept bytes. An odd SCR byte goes to WRITE. Falling ioctl_download goes to FLUSH if an even byte is latched unpaired, else to DONE.
  - WRITE: hold sdram_we, addr and din stable. On sdram_ack, drop sdram_we and ioctl_wait the same cycle. Then go to LOAD, or to DONE if ioctl_download has already fallen. Download falling while in WRITE does not abort the write.
  - FLUSH: issue {hi,8'h00} at the pending even address. Same ack rule as WRITE, then go to DONE.
  - DONE: done=1, then go to IDLE. done stays 1 until the next download starts.
- ioctl_wr arriving while ioctl_wait=1 is a protocol violation. The byte is dropped and must not corrupt the pending write.
- Out-of-order SCR offsets: an odd byte whose even partner was not the immediately preceding SCR byte still writes, using the current hi latch. No reordering.
- Reset mid-WRITE: sdram_we drops the next cycle and the partial word is lost. The renderer may show garbage until a reload.
- Width rules:
  - Offsets compared in 25 bits.
  - pal_addr = offset-ROM_SIZE truncated to 10 bits.
  - rom_addr truncated to 12 bits.
  - sdram_addr bit 0 is always 0.

Decomposition:
- Shared package gnw_pkg:
  - Region base/size localparams derived from parameters.
  - State enum IDLE/LOAD/WRITE/FLUSH/DONE.
- Sub-module gnw_word_packer: byte-pair latch plus SDRAM request/ack holder. It owns sdram_* and ioctl_wait; the top owns decode and the FSM.

Test Plan:
- ROM byte 0xA5 at offset 0x010 -> rom_we pulse 1 cycle later, rom_addr=0x010, rom_dout=0xA5. No pal/sdram activity.
- Palette bytes 0x12,0x34 at offsets 4096,4097 -> pal_load twice, pal_addr=0,1, pal_din=0x12,0x34.
- SCR bytes 0x07,0x9D at offsets 4864,4865 with ack delayed 5 cycles -> sdram_we=1 with addr=0, din=0x079D. ioctl_wait=1 for 6 cycles and drops with ack.
- Download ends after even SCR byte 0x3C at offset 4866 -> FLUSH writes addr=2, din=0x3C00, then done=1.
- reset asserted while WRITE is pending -> the next cycle has sdram_we=0, ioctl_wait=0, done=0, state IDLE. A new download loads normally.
- Byte at offset beyond the image end -> no strobes on any sink; done asserts after the download falls.
